// File: rtl/cmp_iter_if.sv
// ============================================================================
// Module   : cmp_iter_if
// Purpose  : Operand/result handshake bundle for the iterative compare unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmp_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic [3:0]       out_flags;

  // master = execute stage (issues operands, consumes result)
  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_diff, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_diff, out_flags
  );
endinterface

`default_nettype wire

// File: rtl/cmp_iter.sv
// ============================================================================
// Module   : cmp_iter
// Purpose  : Multi-cycle a-b compare, SLICE bits per cycle LSB first, with
//            {LT, EQ, LTU, V} flags and signed/unsigned mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input wire         clk,
  input wire         rst_n,
  cmp_iter_if.slave  bus
);

  localparam int c_nslice = WIDTH / SLICE;
  localparam int c_cnt_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_carry;
  logic               r_zero;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic [WIDTH-1:0]   r_diff;
  logic [3:0]         r_flags;

  logic [SLICE-1:0]   w_a_sl;
  logic [SLICE-1:0]   w_b_sl;
  logic [SLICE:0]     w_sum;
  logic [SLICE-1:0]   w_d;
  logic               w_c;
  logic [WIDTH-1:0]   w_diff_upd;
  logic               w_zero_nxt;
  logic               w_last;
  logic               w_a_msb;
  logic               w_b_msb;
  logic               w_d_msb;
  logic               w_v;
  logic               w_ltu;
  logic               w_lt;

  // Chunk select by compare against each slice index keeps every select in range.
  always_comb begin
    w_a_sl     = '0;
    w_b_sl     = '0;
    w_diff_upd = r_diff;
    for (int i = 0; i < c_nslice; i++) begin
      if (r_cnt == c_cnt_w'(i)) begin
        w_a_sl                       = r_a[i*SLICE +: SLICE];
        w_b_sl                       = r_b[i*SLICE +: SLICE];
        w_diff_upd[i*SLICE +: SLICE] = w_d;
      end
    end
  end

  assign w_sum      = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + {{SLICE{1'b0}}, r_carry};
  assign w_d        = w_sum[SLICE-1:0];
  assign w_c        = w_sum[SLICE];
  assign w_zero_nxt = r_zero & (w_d == '0);
  assign w_last     = (r_cnt == c_cnt_w'(c_nslice - 1));

  // On the last slice the chunk MSB is the operand/result MSB.
  assign w_a_msb = r_a[WIDTH-1];
  assign w_b_msb = r_b[WIDTH-1];
  assign w_d_msb = w_d[SLICE-1];
  assign w_v     = (w_a_msb ^ w_b_msb) & (w_a_msb ^ w_d_msb);
  assign w_ltu   = ~w_c;
  assign w_lt    = r_signed ? (w_d_msb ^ w_v) : w_ltu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b1;
      r_zero   <= 1'b1;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_diff   <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.in_a;
            r_b      <= bus.in_b;
            r_signed <= bus.in_signed;
            r_diff   <= '0;
            r_carry  <= 1'b1;
            r_zero   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff  <= w_diff_upd;
          r_carry <= w_c;
          r_zero  <= w_zero_nxt;
          if (w_last) begin
            r_flags <= {w_lt, w_zero_nxt, w_ltu, w_v};
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_diff  = r_diff;
  assign bus.out_flags = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_cmp_iter.sv
// ============================================================================
// Module   : tb_cmp_iter
// Purpose  : Directed and parameter-sweep checks of cmp_iter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cmp_iter_if #(.WIDTH(32)) b0 ();
  cmp_iter_if #(.WIDTH(16)) b1 ();
  cmp_iter_if #(.WIDTH(64)) b2 ();
  cmp_iter_if #(.WIDTH(8))  b3 ();

  cmp_iter #(.WIDTH(32), .SLICE(8))  u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  cmp_iter #(.WIDTH(16), .SLICE(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  cmp_iter #(.WIDTH(64), .SLICE(8))  u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  cmp_iter #(.WIDTH(8),  .SLICE(1))  u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  function automatic int width_of(input int inst);
    case (inst)
      0: return 32;
      1: return 16;
      2: return 64;
      default: return 8;
    endcase
  endfunction

  function automatic int nslice_of(input int inst);
    case (inst)
      0: return 4;
      1: return 1;
      2: return 8;
      default: return 8;
    endcase
  endfunction

  task automatic drive_in(input int inst, input logic v, input logic [63:0] a,
                          input logic [63:0] b, input logic s);
    case (inst)
      0: begin b0.in_valid = v; b0.in_a = a[31:0]; b0.in_b = b[31:0]; b0.in_signed = s; end
      1: begin b1.in_valid = v; b1.in_a = a[15:0]; b1.in_b = b[15:0]; b1.in_signed = s; end
      2: begin b2.in_valid = v; b2.in_a = a;       b2.in_b = b;       b2.in_signed = s; end
      default: begin b3.in_valid = v; b3.in_a = a[7:0]; b3.in_b = b[7:0]; b3.in_signed = s; end
    endcase
  endtask

  task automatic set_oready(input int inst, input logic r);
    case (inst)
      0: b0.out_ready = r;
      1: b1.out_ready = r;
      2: b2.out_ready = r;
      default: b3.out_ready = r;
    endcase
  endtask

  function automatic logic get_valid(input int inst);
    case (inst)
      0: return b0.out_valid;
      1: return b1.out_valid;
      2: return b2.out_valid;
      default: return b3.out_valid;
    endcase
  endfunction

  function automatic logic [63:0] get_diff(input int inst);
    case (inst)
      0: return {32'd0, b0.out_diff};
      1: return {48'd0, b1.out_diff};
      2: return b2.out_diff;
      default: return {56'd0, b3.out_diff};
    endcase
  endfunction

  function automatic logic [3:0] get_flags(input int inst);
    case (inst)
      0: return b0.out_flags;
      1: return b1.out_flags;
      2: return b2.out_flags;
      default: return b3.out_flags;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference from whole-word arithmetic: signed order via sign-bit flip.
  task automatic ref_model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                           input logic s, output logic [63:0] d, output logic [3:0] f);
    logic [63:0] mask, sb, a, b;
    logic ltu, eq, v, lt;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    sb   = 64'd1 << (w - 1);
    a    = a_in & mask;
    b    = b_in & mask;
    d    = (a - b) & mask;
    ltu  = (a < b);
    eq   = (a == b);
    v    = (((a ^ b) & (a ^ d) & sb) != 64'd0);
    lt   = s ? ((a ^ sb) < (b ^ sb)) : ltu;
    f    = {lt, eq, ltu, v};
  endtask

  task automatic run_op(input int inst, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input bit release_out,
                        output logic [63:0] d, output logic [3:0] f, output int lat);
    @(negedge clk);
    drive_in(inst, 1'b1, a, b, s);
    @(posedge clk); #1;
    // Scramble the inputs after accept; the result must not change.
    drive_in(inst, 1'b0, ~a, {$urandom, $urandom}, ~s);
    lat = 0;
    while (!get_valid(inst) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    d = get_diff(inst);
    f = get_flags(inst);
    if (release_out) begin
      set_oready(inst, 1'b1);
      @(posedge clk); #1;
      set_oready(inst, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] d, ed, ra, rb;
    logic [3:0]  f, ef;
    logic        rs;
    int          lat;

    for (int i = 0; i < 4; i++) begin
      drive_in(i, 1'b0, 64'd0, 64'd0, 1'b0);
      set_oready(i, 1'b0);
    end
    #3;
    check("rst_in_ready", {63'd0, b0.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, b0.out_valid}, 64'd0);
    check("rst_diff", get_diff(0), 64'd0);
    check("rst_flags", {60'd0, b0.out_flags}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic signed/unsigned vectors on the 32/8 instance
    run_op(0, 64'd5, 64'd7, 1'b1, 1'b1, d, f, lat);
    check("t1_lat", 64'(lat), 64'd4);
    check("t1_diff", d, 64'hFFFF_FFFE);
    check("t1_flags", {60'd0, f}, 64'b1010);

    run_op(0, 64'h8000_0000, 64'h1, 1'b1, 1'b1, d, f, lat);
    check("t2s_diff", d, 64'h7FFF_FFFF);
    check("t2s_flags", {60'd0, f}, 64'b1001);
    run_op(0, 64'h8000_0000, 64'h1, 1'b0, 1'b1, d, f, lat);
    check("t2u_flags", {60'd0, f}, 64'b0001);

    run_op(0, 64'h1234_5678, 64'h1234_5678, 1'b1, 1'b1, d, f, lat);
    check("t3s_diff", d, 64'd0);
    check("t3s_flags", {60'd0, f}, 64'b0100);
    run_op(0, 64'h1234_5678, 64'h1234_5678, 1'b0, 1'b1, d, f, lat);
    check("t3u_flags", {60'd0, f}, 64'b0100);
    run_op(0, 64'd0, 64'hFFFF_FFFF, 1'b0, 1'b1, d, f, lat);
    check("t3w_diff", d, 64'd1);
    check("t3w_flags", {60'd0, f}, 64'b1010);

    // Backpressure: result held, new request ignored
    run_op(0, 64'd3, 64'd1, 1'b0, 1'b0, d, f, lat);
    check("t4_diff", d, 64'd2);
    check("t4_flags", {60'd0, f}, 64'b0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_in(0, (c == 1), 64'd100, 64'd50, 1'b1);
      @(posedge clk); #1;
      check("t4_hold_valid", {63'd0, b0.out_valid}, 64'd1);
      check("t4_hold_diff", get_diff(0), 64'd2);
      check("t4_hold_flags", {60'd0, b0.out_flags}, 64'd0);
      check("t4_hold_ready", {63'd0, b0.in_ready}, 64'd0);
    end
    @(negedge clk);
    drive_in(0, 1'b0, 64'd0, 64'd0, 1'b0);
    set_oready(0, 1'b1);
    @(posedge clk); #1;
    set_oready(0, 1'b0);
    check("t4_rel_valid", {63'd0, b0.out_valid}, 64'd0);
    check("t4_rel_ready", {63'd0, b0.in_ready}, 64'd1);
    run_op(0, 64'd10, 64'd3, 1'b0, 1'b1, d, f, lat);
    check("t4_next_lat", 64'(lat), 64'd4);
    check("t4_next_diff", d, 64'd7);

    // Reset in RUN with counter at 2
    @(negedge clk);
    drive_in(0, 1'b1, 64'h1234, 64'h1, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("t5_rst_valid", {63'd0, b0.out_valid}, 64'd0);
      check("t5_rst_ready", {63'd0, b0.in_ready}, 64'd1);
      check("t5_rst_flags", {60'd0, b0.out_flags}, 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 64'd9, 64'd9, 1'b1, 1'b1, d, f, lat);
    check("t5_after_lat", 64'(lat), 64'd4);
    check("t5_after_flags", {60'd0, f}, 64'b0100);

    // Random sweep over all geometries
    for (int inst = 0; inst < 4; inst++) begin
      for (int n = 0; n < 40; n++) begin
        ra = {$urandom, $urandom};
        rb = (n % 8 == 0) ? ra : {$urandom, $urandom};
        rs = 1'($urandom_range(0, 1));
        ref_model(width_of(inst), ra, rb, rs, ed, ef);
        run_op(inst, ra, rb, rs, 1'b1, d, f, lat);
        check($sformatf("sweep%0d_lat", inst), 64'(lat), 64'(nslice_of(inst)));
        check($sformatf("sweep%0d_diff", inst), d, ed);
        check($sformatf("sweep%0d_flags", inst), {60'd0, f}, {60'd0, ef});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
